// File: rtl/weight_server.sv
// Final-layer weight memory responder: host load port, 2-cycle pipelined reads with region checking.
// Optional macro WEIGHT_SERVER_DEFAULT_EN: unwritten words read back as per-type default values.
module weight_server #(
  parameter  int WIDTH               = 16,
  parameter  int IN_CHANNELS         = 16,
  parameter  int MID_CHANNELS        = 32,
  parameter  int LINEAR_FEATURES_IN  = 32,
  parameter  int LINEAR_FEATURES_MID = 64,
  parameter  int NUM_CLASSES         = 15,
  localparam int DEPTH = IN_CHANNELS * MID_CHANNELS + MID_CHANNELS * 2
                       + LINEAR_FEATURES_MID * LINEAR_FEATURES_IN + LINEAR_FEATURES_MID * 3
                       + NUM_CLASSES * LINEAR_FEATURES_MID + NUM_CLASSES,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              load_done,
  input  logic              weight_req,
  input  logic [ADDR_W-1:0] weight_addr,
  input  logic [3:0]        weight_type,
  output logic [WIDTH-1:0]  weight_data,
  output logic              weight_valid,
  output logic              serving,
  output logic              err,
  output logic [7:0]        err_count
);

  localparam int NUM_REGIONS = 9;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  // Region sizes in memory order; bases are the running sum of the preceding sizes.
  function automatic int region_size(input int t);
    case (t)
      0:       return IN_CHANNELS * MID_CHANNELS;
      1, 2:    return MID_CHANNELS;
      3:       return LINEAR_FEATURES_MID * LINEAR_FEATURES_IN;
      4, 5, 6: return LINEAR_FEATURES_MID;
      7:       return NUM_CLASSES * LINEAR_FEATURES_MID;
      default: return NUM_CLASSES;
    endcase
  endfunction

  function automatic int region_base(input int t);
    int b;
    b = 0;
    for (int i = 0; i < t; i++) b += region_size(i);
    return b;
  endfunction

  typedef enum logic {LOAD, SERVE} state_t;

  state_t state_reg, state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= LOAD;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (load_done) state_next = SERVE;
      SERVE:   if (load_done) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  logic in_load;
  logic load_addr_ok;
  logic mem_we;
  logic rd_accept;
  logic addr_in_range;
  logic check_ok;
  logic err_event;
  logic [NUM_REGIONS-1:0] region_hit;

  assign in_load       = (state_reg == LOAD);
  assign serving       = (state_reg == SERVE);
  assign load_addr_ok  = (load_addr < DEPTH_A);
  assign mem_we        = in_load && load_we && load_addr_ok;
  assign rd_accept     = !in_load && weight_req;
  assign addr_in_range = (weight_addr < DEPTH_A);

  // One extra bit on the offset so addresses below the base show up as negative.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
      localparam logic [ADDR_W:0] BASE = (ADDR_W+1)'(region_base(gi));
      localparam logic [ADDR_W:0] SIZE = (ADDR_W+1)'(region_size(gi));
      logic [ADDR_W:0] offset;
      assign offset         = {1'b0, weight_addr} - BASE;
      assign region_hit[gi] = (weight_type == 4'(gi)) && !offset[ADDR_W] && (offset < SIZE);
    end
  endgenerate

  assign check_ok  = addr_in_range && (|region_hit);
  assign err_event = (in_load && load_we && !load_addr_ok)
                   || (in_load && weight_req)
                   || (!in_load && load_we)
                   || (rd_accept && !check_ok);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (mem_we) mem[load_addr] <= load_data;
    rd_data_reg <= mem[weight_addr];
  end

  logic [WIDTH-1:0] rd_word;

`ifdef WEIGHT_SERVER_DEFAULT_EN
  function automatic logic [WIDTH-1:0] type_default(input logic [3:0] t);
    case (t)
      4'd1, 4'd5: return WIDTH'(16'h0100);
      4'd2, 4'd6: return '0;
      4'd4, 4'd8: return WIDTH'(16'h0040);
      default:    return WIDTH'(16'h0010);
    endcase
  endfunction

  logic [DEPTH-1:0] written_reg;
  logic             s1_written_reg;
  logic [3:0]       s1_type_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_reg    <= '0;
      s1_written_reg <= 1'b0;
      s1_type_reg    <= '0;
    end else begin
      if (mem_we) written_reg[load_addr] <= 1'b1;
      s1_written_reg <= written_reg[weight_addr];
      s1_type_reg    <= weight_type;
    end
  end

  assign rd_word = s1_written_reg ? rd_data_reg : type_default(s1_type_reg);
`else
  assign rd_word = rd_data_reg;
`endif

  logic             s1_valid_reg;
  logic             s1_ok_reg;
  logic             weight_valid_reg;
  logic [WIDTH-1:0] weight_data_reg;
  logic             err_reg;
  logic [7:0]       err_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg     <= 1'b0;
      s1_ok_reg        <= 1'b0;
      weight_valid_reg <= 1'b0;
      weight_data_reg  <= '0;
      err_reg          <= 1'b0;
      err_count_reg    <= '0;
    end else begin
      s1_valid_reg     <= rd_accept;
      s1_ok_reg        <= check_ok;
      weight_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) weight_data_reg <= s1_ok_reg ? rd_word : '0;
      if (err_event) begin
        err_reg <= 1'b1;
        if (err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  assign weight_valid = weight_valid_reg;
  assign weight_data  = weight_data_reg;
  assign err          = err_reg;
  assign err_count    = err_count_reg;

endmodule

// File: tb/tb_weight_server.sv
// Directed testbench for weight_server: reset, load/serve, streaming, region checks, error saturation.
module tb_weight_server;

  localparam int AW = 12;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [W-1:0]  load_data = '0;
  logic          load_done = 1'b0;
  logic          weight_req = 1'b0;
  logic [AW-1:0] weight_addr = '0;
  logic [3:0]    weight_type = '0;
  logic [W-1:0]  weight_data;
  logic          weight_valid;
  logic          serving;
  logic          err;
  logic [7:0]    err_count;

  int checks = 0;
  int errors = 0;

  weight_server dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_done   (load_done),
    .weight_req  (weight_req),
    .weight_addr (weight_addr),
    .weight_type (weight_type),
    .weight_data (weight_data),
    .weight_valid(weight_valid),
    .serving     (serving),
    .err         (err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_word(input int a, input int d);
    load_we   = 1'b1;
    load_addr = AW'(a);
    load_data = W'(d);
    tick();
    load_we   = 1'b0;
  endtask

  task automatic pulse_done();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  // Single request, then wait the two-cycle latency and check the response.
  task automatic read_one(input string tag, input int a, input int t, input int exp_data);
    weight_req  = 1'b1;
    weight_addr = AW'(a);
    weight_type = 4'(t);
    tick();
    weight_req  = 1'b0;
    tick();
    $display("read %s addr=%0d type=%0d -> valid=%b data=%h err_count=%0d",
             tag, a, t, weight_valid, weight_data, err_count);
    check({tag, "_valid"}, 32'(weight_valid), 32'd1);
    check({tag, "_data"}, 32'(weight_data), 32'(exp_data));
  endtask

  initial begin
    logic any_valid;

    // Reset state
    #12;
    check("rst_valid", 32'(weight_valid), 32'd0);
    check("rst_data", 32'(weight_data), 32'd0);
    check("rst_serving", 32'(serving), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Load phase
    for (int a = 0; a < 512; a++) load_word(a, a);
    load_word(512, 16'h0100);
    load_word(3776, 16'h0040);
    check("load_no_err", 32'(err_count), 32'd0);
    check("load_serving", 32'(serving), 32'd0);
    pulse_done();
    check("serve_entered", 32'(serving), 32'd1);

    // Back-to-back requests in two different regions
    weight_req = 1'b1; weight_addr = 12'd512;  weight_type = 4'd1;
    tick();
    weight_addr = 12'd3776; weight_type = 4'd8;
    tick();
    weight_req = 1'b0;
    $display("b2b first  -> valid=%b data=%h", weight_valid, weight_data);
    check("b2b0_valid", 32'(weight_valid), 32'd1);
    check("b2b0_data", 32'(weight_data), 32'h0100);
    tick();
    $display("b2b second -> valid=%b data=%h", weight_valid, weight_data);
    check("b2b1_valid", 32'(weight_valid), 32'd1);
    check("b2b1_data", 32'(weight_data), 32'h0040);
    tick();
    check("b2b_idle_valid", 32'(weight_valid), 32'd0);
    check("b2b_hold_data", 32'(weight_data), 32'h0040);
    check("b2b_no_err", 32'(err), 32'd0);

    // Streaming 512 consecutive requests
    for (int c = 0; c <= 512; c++) begin
      if (c < 512) begin
        weight_req = 1'b1; weight_addr = AW'(c); weight_type = 4'd0;
      end else begin
        weight_req = 1'b0;
      end
      tick();
      if (c >= 1) begin
        check("stream_valid", 32'(weight_valid), 32'd1);
        check("stream_data", 32'(weight_data), 32'(c - 1));
      end
    end
    tick();
    $display("stream done: 512 requests, last data=%h", weight_data);
    check("stream_end_valid", 32'(weight_valid), 32'd0);
    check("stream_end_data", 32'(weight_data), 32'd511);

    // Region mismatches and boundaries
    read_one("mismatch_600_t1", 600, 1, 0);
    check("mismatch_err", 32'(err), 32'd1);
    check("mismatch_count", 32'(err_count), 32'd1);
    read_one("bad_type9", 0, 9, 0);
    check("type9_count", 32'(err_count), 32'd2);
    read_one("addr_depth", 3791, 8, 0);
    check("depth_count", 32'(err_count), 32'd3);
    read_one("t0_past_last", 512, 0, 0);
    check("t0_past_count", 32'(err_count), 32'd4);
    read_one("t0_last", 511, 0, 511);
    check("t0_last_count", 32'(err_count), 32'd4);

    // Host write while serving is dropped and flagged
    load_word(0, 16'hBEEF);
    check("serve_we_count", 32'(err_count), 32'd5);
    read_one("after_serve_we", 0, 0, 0);

    // load_done in SERVE with a request in flight
    weight_req = 1'b1; weight_addr = 12'd511; weight_type = 4'd0; load_done = 1'b1;
    tick();
    weight_req = 1'b0; load_done = 1'b0;
    check("back_to_load", 32'(serving), 32'd0);
    tick();
    $display("in-flight at load_done -> valid=%b data=%h", weight_valid, weight_data);
    check("inflight_valid", 32'(weight_valid), 32'd1);
    check("inflight_data", 32'(weight_data), 32'd511);
    check("inflight_count", 32'(err_count), 32'd5);

    // Reset in the middle of a stream
    pulse_done();
    weight_req = 1'b1; weight_addr = 12'd5; weight_type = 4'd0;
    tick();
    tick();
    check("pre_rst_valid", 32'(weight_valid), 32'd1);
    weight_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(weight_valid), 32'd0);
    check("mid_rst_serving", 32'(serving), 32'd0);
    check("mid_rst_count", 32'(err_count), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_valid", 32'(weight_valid), 32'd0);
      check("post_rst_serving", 32'(serving), 32'd0);
    end

    // Errors in LOAD state, simultaneous sources, saturation
    weight_req = 1'b1; weight_addr = 12'd0; weight_type = 4'd0;
    tick();
    weight_req = 1'b0;
    check("load_req_count", 32'(err_count), 32'd1);
    check("load_req_err", 32'(err), 32'd1);
    tick();
    check("load_req_no_valid", 32'(weight_valid), 32'd0);
    load_word(3791, 16'h1234);
    check("load_oob_count", 32'(err_count), 32'd2);
    load_we = 1'b1; load_addr = 12'd4000; weight_req = 1'b1;
    tick();
    load_we = 1'b0; weight_req = 1'b0;
    check("simul_count", 32'(err_count), 32'd3);
    any_valid  = 1'b0;
    weight_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      any_valid |= weight_valid;
    end
    weight_req = 1'b0;
    tick();
    any_valid |= weight_valid;
    $display("load-state flood: err_count=%0d", err_count);
    check("flood_no_valid", 32'(any_valid), 32'd0);
    check("sat_count", 32'(err_count), 32'd255);
    check("sat_err", 32'(err), 32'd1);

`ifdef WEIGHT_SERVER_DEFAULT_EN
    // Unwritten words read back as type defaults
    #2 rst_n = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    pulse_done();
    weight_req = 1'b1; weight_addr = 12'd2700; weight_type = 4'd5;
    tick();
    weight_addr = 12'd2624; weight_type = 4'd4;
    tick();
    weight_addr = 12'd0; weight_type = 4'd0;
    check("dflt_gamma", 32'(weight_data), 32'h0100);
    tick();
    weight_req = 1'b0;
    check("dflt_bias", 32'(weight_data), 32'h0040);
    tick();
    $display("defaults: last data=%h valid=%b", weight_data, weight_valid);
    check("dflt_weight", 32'(weight_data), 32'h0010);
    check("dflt_valid", 32'(weight_valid), 32'd1);
    check("dflt_count", 32'(err_count), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
